li_shell: RTL and testbench

Latency-insensitive shell that terminates two incoming `li_link` channels and drives one outgoing `li_link` on behalf of a synchronous pearl (IP core). It is the endpoint counterpart of the relay station: relay stations carry tokens along a link, and the shell consumes them at the far end. Each input has a small queue. The shell fires the pearl only when both operands are present and the output slot can accept a result, then launches the registered result downstream under the same valid/stop protocol.

---
 rtl/li_shell_pkg.sv | 21 ++
 rtl/li_link.sv | 15 +
 rtl/li_shell_queue.sv | 79 +++++++
 rtl/li_shell.sv | 107 ++++++++++
 tb/tb_li_shell.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/li_shell_pkg.sv
// li_shell_pkg: shared constants and types for the latency-insensitive shell.
//   - Default widths and queue depth used as parameter defaults.
//   - slot_state_e: state of the single-entry output slot (S_EMPTY, S_FULL).
//   - ptr_width(): queue pointer width, never less than 1 bit.
package li_shell_pkg;

  localparam int DEF_WIDTH_A     = 6;
  localparam int DEF_WIDTH_B     = 6;
  localparam int DEF_WIDTH_OUT   = 6;
  localparam int DEF_QUEUE_DEPTH = 2;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/li_link.sv
// li_link: latency-insensitive point-to-point channel.
//   data  : payload, WIDTH bits, meaningful only when valid is high
//   valid : token present (valid=0 is a void token)
//   stop  : backpressure from the consumer; a token moves when valid & ~stop
// Modports: source (drives data/valid, receives stop), sink (the reverse).
interface li_link #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             stop;

  modport source (output data, output valid, input stop);
  modport sink   (input data, input valid, output stop);
endinterface

// File: rtl/li_shell_queue.sv
// li_shell_queue: per-input FIFO of the latency-insensitive shell.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   enq_data/enq_valid : incoming link token
//   stop         : Moore backpressure, high exactly when the queue is full
//   head_data    : oldest entry (or the bypassed token, see byp_en)
//   not_empty    : an operand is available at head_data
//   deq          : consume the head this cycle
//   byp_en       : bypass hook; when high an empty queue presents the
//                  incoming valid token at the head, and a same-cycle deq
//                  consumes it without it ever being stored
module li_shell_queue
  import li_shell_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH_A,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             enq_valid,
  output logic             stop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  input  logic             deq,
  input  logic             byp_en
);

  localparam int              PW       = ptr_width(DEPTH);
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  logic stored;
  logic byp_hit;
  logic do_enq;
  logic do_deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign stored    = (cnt != '0);
  assign stop      = (cnt == FULL_CNT);
  assign byp_hit   = byp_en & ~stored & enq_valid;
  assign head_data = byp_hit ? enq_data : mem[rd_ptr];
  assign not_empty = stored | byp_hit;

  // A bypassed token that is consumed in its arrival cycle is never written.
  assign do_enq = enq_valid & ~stop & ~(byp_hit & deq);
  assign do_deq = deq & stored;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= next_ptr(wr_ptr);
      if (do_deq) rd_ptr <= next_ptr(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/li_shell.sv
// li_shell: latency-insensitive shell around a synchronous pearl.
// Terminates two li_link inputs (in_a, in_b) in small queues, fires the
// pearl when both operands are present and the output slot can take a
// result, and launches the registered result on out_link.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   in_a, in_b    : li_link sinks (operands)
//   out_link      : li_link source (results)
//   pearl_en      : fire strobe, pearl advances only when high
//   pearl_a/b     : queue heads presented to the pearl
//   pearl_result  : combinational pearl output, captured on fire
// Build option: define LI_SHELL_BYPASS_EN to let an empty queue forward an
// arriving token straight to the pearl (minimum latency 1 instead of 2).
module li_shell
  import li_shell_pkg::*;
#(
  parameter int WIDTH_A     = DEF_WIDTH_A,
  parameter int WIDTH_B     = DEF_WIDTH_B,
  parameter int WIDTH_OUT   = DEF_WIDTH_OUT,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  li_link.sink                 in_a,
  li_link.sink                 in_b,
  li_link.source               out_link,
  output logic                 pearl_en,
  output logic [WIDTH_A-1:0]   pearl_a,
  output logic [WIDTH_B-1:0]   pearl_b,
  input  logic [WIDTH_OUT-1:0] pearl_result
);

`ifdef LI_SHELL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                 ne_a;
  logic                 ne_b;
  logic                 fire;
  slot_state_e          slot_state_p1;
  logic                 vld_p1;
  logic [WIDTH_OUT-1:0] data_p1;

  // Stage p0: input queues and fire decision
  li_shell_queue #(.WIDTH(WIDTH_A), .DEPTH(QUEUE_DEPTH)) u_queue_a (
    .clk       (clk),
    .reset     (reset),
    .enq_data  (in_a.data),
    .enq_valid (in_a.valid),
    .stop      (in_a.stop),
    .head_data (pearl_a),
    .not_empty (ne_a),
    .deq       (fire),
    .byp_en    (BYP)
  );

  li_shell_queue #(.WIDTH(WIDTH_B), .DEPTH(QUEUE_DEPTH)) u_queue_b (
    .clk       (clk),
    .reset     (reset),
    .enq_data  (in_b.data),
    .enq_valid (in_b.valid),
    .stop      (in_b.stop),
    .head_data (pearl_b),
    .not_empty (ne_b),
    .deq       (fire),
    .byp_en    (BYP)
  );

  // A full slot under stop blocks firing; reset suppresses a bypass fire.
  assign fire     = ne_a & ne_b & (~vld_p1 | ~out_link.stop) & ~reset;
  assign pearl_en = fire;

  // Stage p1: registered output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_state_p1 <= S_EMPTY;
      vld_p1        <= 1'b0;
      data_p1       <= '0;
    end else begin
      case (slot_state_p1)
        S_EMPTY: begin
          if (fire) begin
            data_p1       <= pearl_result;
            vld_p1        <= 1'b1;
            slot_state_p1 <= S_FULL;
          end
        end
        S_FULL: begin
          if (!out_link.stop) begin
            if (fire) begin
              data_p1 <= pearl_result;
            end else begin
              vld_p1        <= 1'b0;
              slot_state_p1 <= S_EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign out_link.valid = vld_p1;
  assign out_link.data  = data_p1;

endmodule

// File: tb/tb_li_shell.sv
module tb_li_shell;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  li_link #(.WIDTH(W)) a_if ();
  li_link #(.WIDTH(W)) b_if ();
  li_link #(.WIDTH(W)) o_if ();

  logic         pearl_en;
  logic [W-1:0] pearl_a;
  logic [W-1:0] pearl_b;
  logic [W-1:0] pearl_result;

  // Pearl model: stateless adder.
  assign pearl_result = pearl_a + pearl_b;

  li_shell #(
    .WIDTH_A(W), .WIDTH_B(W), .WIDTH_OUT(W), .QUEUE_DEPTH(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_a         (a_if),
    .in_b         (b_if),
    .out_link     (o_if),
    .pearl_en     (pearl_en),
    .pearl_a      (pearl_a),
    .pearl_b      (pearl_b),
    .pearl_result (pearl_result)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle and let combinational paths settle.
  task automatic drive(input logic va, input logic [W-1:0] da,
                       input logic vb, input logic [W-1:0] db);
    a_if.valid = va;
    a_if.data  = da;
    b_if.valid = vb;
    b_if.data  = db;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  int   ia, ib, nrx;
  logic sent_a, sent_b;

  initial begin
    reset      = 1'b1;
    o_if.stop  = 1'b0;
    a_if.valid = 1'b0;
    a_if.data  = '0;
    b_if.valid = 1'b0;
    b_if.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stop_a", a_if.stop, 0);
    check("rst_stop_b", b_if.stop, 0);
    check("rst_valid", o_if.valid, 0);
    check("rst_data", o_if.data, 0);
    check("rst_en", pearl_en, 0);
    reset = 1'b0;
    next_cycle();

    // Streaming: 1,2,3 + 10,20,30 -> 11,22,33 from two cycles later.
    drive(1, 1, 1, 10); check("str_en_c0", pearl_en, 0); next_cycle();
    drive(1, 2, 1, 20); check("str_en_c1", pearl_en, 1);
    check("str_vld_c1", o_if.valid, 0); next_cycle();
    drive(1, 3, 1, 30); check("str_en_c2", pearl_en, 1);
    check("str_vld_c2", o_if.valid, 1); check("str_dat_c2", o_if.data, 11); next_cycle();
    idle(); check("str_en_c3", pearl_en, 1);
    check("str_vld_c3", o_if.valid, 1); check("str_dat_c3", o_if.data, 22); next_cycle();
    idle(); check("str_en_c4", pearl_en, 0);
    check("str_vld_c4", o_if.valid, 1); check("str_dat_c4", o_if.data, 33); next_cycle();
    idle(); check("str_vld_c5", o_if.valid, 0); next_cycle();

    // Asymmetric arrival: a=5 at cycle 0, b=7 at cycle 6.
    for (int c = 0; c <= 9; c++) begin
      drive(c == 0, 5, c == 6, 7);
      check("asym_stop_a", a_if.stop, 0);
      check("asym_en", pearl_en, (c == 7));
      check("asym_vld", o_if.valid, (c == 8));
      if (c == 8) check("asym_dat", o_if.data, 12);
      next_cycle();
    end

    // Backpressure: out stop held 10 cycles while 6 pairs stream.
    ia = 0; ib = 0; nrx = 0;
    for (int c = 0; c < 40; c++) begin
      o_if.stop = (c < 10);
      drive(ia < 6, W'(ia + 1), ib < 6, W'(2 * (ib + 1)));
      if (c >= 3 && c < 10) begin
        check("bp_stop_a", a_if.stop, 1);
        check("bp_stop_b", b_if.stop, 1);
      end
      if (c >= 2 && c < 10) begin
        check("bp_hold_vld", o_if.valid, 1);
        check("bp_hold_dat", o_if.data, 3);
      end
      sent_a = a_if.valid & ~a_if.stop;
      sent_b = b_if.valid & ~b_if.stop;
      if (o_if.valid & ~o_if.stop) begin
        if (nrx < 6) check("bp_rx", o_if.data, 3 * (nrx + 1));
        else check("bp_extra", o_if.valid, 0);
        nrx++;
      end
      next_cycle();
      if (sent_a) ia++;
      if (sent_b) ib++;
    end
    check("bp_count", nrx, 6);
    o_if.stop = 1'b0;

    // Void tokens: garbage with valid=0 is never enqueued or fired.
    drive(1, 1, 1, 2); next_cycle();
    drive(0, 63, 0, 63); check("void_en_c1", pearl_en, 1); next_cycle();
    drive(0, 42, 0, 17); check("void_vld_c2", o_if.valid, 1);
    check("void_dat_c2", o_if.data, 3); check("void_en_c2", pearl_en, 0);
    check("void_stop_a", a_if.stop, 0); next_cycle();
    drive(0, 5, 0, 9); check("void_vld_c3", o_if.valid, 0);
    check("void_en_c3", pearl_en, 0); next_cycle();
    drive(1, 4, 1, 5); check("void_en_c4", pearl_en, 0); next_cycle();
    idle(); check("void_en_c5", pearl_en, 1); check("void_vld_c5", o_if.valid, 0); next_cycle();
    idle(); check("void_vld_c6", o_if.valid, 1); check("void_dat_c6", o_if.data, 9); next_cycle();

    // Reset mid-stream: slot full under stop, one entry in each queue.
    o_if.stop = 1'b1;
    drive(1, 1, 1, 1); next_cycle();
    drive(1, 2, 1, 2); next_cycle();
    idle(); check("mrst_pre_vld", o_if.valid, 1); check("mrst_pre_en", pearl_en, 0);
    reset = 1'b1;
    #1;
    check("mrst_stop_a", a_if.stop, 0);
    check("mrst_stop_b", b_if.stop, 0);
    check("mrst_vld", o_if.valid, 0);
    check("mrst_dat", o_if.data, 0);
    check("mrst_en", pearl_en, 0);
    next_cycle();
    reset = 1'b0;
    o_if.stop = 1'b0;
    next_cycle();
    idle(); check("mrst_r0_en", pearl_en, 0); check("mrst_r0_vld", o_if.valid, 0); next_cycle();
    drive(1, 7, 1, 8); check("mrst_r1_en", pearl_en, 0); next_cycle();
    idle(); check("mrst_r2_en", pearl_en, 1); check("mrst_r2_vld", o_if.valid, 0); next_cycle();
    idle(); check("mrst_r3_vld", o_if.valid, 1); check("mrst_r3_dat", o_if.data, 15); next_cycle();
    idle(); next_cycle();

    // Simultaneous arrival on empty queues: 3 + 4.
    drive(1, 3, 1, 4);
`ifdef LI_SHELL_BYPASS_EN
    check("byp_en_c0", pearl_en, 1); next_cycle();
    idle(); check("byp_vld_c1", o_if.valid, 1); check("byp_dat_c1", o_if.data, 7); next_cycle();
    idle(); check("byp_vld_c2", o_if.valid, 0); next_cycle();
`else
    check("byp_en_c0", pearl_en, 0); next_cycle();
    idle(); check("byp_en_c1", pearl_en, 1); check("byp_vld_c1", o_if.valid, 0); next_cycle();
    idle(); check("byp_vld_c2", o_if.valid, 1); check("byp_dat_c2", o_if.data, 7); next_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
